// File: rtl/mole_button_frontend.sv
// mole_button_frontend: synchronizes, debounces and edge-detects the raw button pins.
// Optional stuck-button detection is enabled by defining BTN_STUCK_DETECT_EN.
module mole_button_frontend #(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press,
    output logic [N_BTN-1:0] btn_stuck
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic             any_q, any_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [N_BTN-1:0] stuck_gate;

`ifdef BTN_STUCK_DETECT_EN
    localparam int HW = $clog2(STUCK_CYCLES + 1);

    logic [HW-1:0]    hold_q [N_BTN];
    logic [HW-1:0]    hold_d [N_BTN];
    logic [N_BTN-1:0] stuck_q, stuck_d;
    logic [N_BTN-1:0] level_q, level_d;

    // Hold counters run while the debounced level stays high; a falling level clears them.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            hold_d[i] = '0;
            if (stable_q[i] && stable_d[i])
                hold_d[i] = (hold_q[i] == HW'(STUCK_CYCLES)) ? hold_q[i] : hold_q[i] + 1'b1;
            stuck_d[i] = stable_q[i] && stable_d[i] && (stuck_q[i] || hold_d[i] == HW'(STUCK_CYCLES));
        end
        level_d = stable_d & ~stuck_d;
    end

    // Stuck-detection state; cleared by reset or a disabled tile.
    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            hold_q  <= '{default: '0};
            stuck_q <= '0;
            level_q <= '0;
        end else begin
            hold_q  <= hold_d;
            stuck_q <= stuck_d;
            level_q <= level_d;
        end
    end

    assign stuck_gate = stuck_q;
    assign btn_level  = level_q;
    assign btn_stuck  = stuck_q;
`else
    assign stuck_gate = '0;
    assign btn_level  = stable_q;
    assign btn_stuck  = '0;
`endif

    // Synchronizer, per-bit debounce counters and registered edge pulses.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        for (int i = 0; i < N_BTN; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q & ~stuck_gate;
        any_d     = |press_d;
    end

    // Core state; reset and ena=0 both clear everything without producing pulses.
    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cnt_q     <= '{default: '0};
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign any_press   = any_q;
endmodule

// File: tb/tb_mole_button_frontend.sv
// tb_mole_button_frontend: directed checks of debounce latency, pulses, ena clear and stuck flag.
module tb_mole_button_frontend;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] btn_raw = 8'hFF;
    logic [7:0] btn_level, btn_press, btn_release, btn_stuck;
    logic       any_press;
    int         checks = 0;
    int         errors = 0;

`ifdef BTN_STUCK_DETECT_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    mole_button_frontend #(.N_BTN(8), .DEBOUNCE_CYCLES(4), .STUCK_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .ena(ena), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .any_press(any_press), .btn_stuck(btn_stuck)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] lvl, input logic [7:0] prs,
                           input logic [7:0] rel, input logic [7:0] stk);
        chk({tag, ".level"}, btn_level, lvl);
        chk({tag, ".press"}, btn_press, prs);
        chk({tag, ".release"}, btn_release, rel);
        chk({tag, ".any"}, {7'b0, any_press}, {7'b0, |prs});
        chk({tag, ".stuck"}, btn_stuck, stk);
    endtask

    task automatic hold(input string tag, input int n, input logic [7:0] lvl);
        repeat (n) begin
            tick();
            chk_out(tag, lvl, 8'h00, 8'h00, 8'h00);
        end
    endtask

    initial begin
        repeat (3) begin
            tick();
            chk_out("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        rst = 1'b0;
        hold("rst_wait", 5, 8'h00);
        tick(); chk_out("rst_rise", 8'hFF, 8'hFF, 8'h00, 8'h00);
        tick(); chk_out("rst_held", 8'hFF, 8'h00, 8'h00, 8'h00);
        btn_raw = 8'h00;
        hold("all_fall_wait", 5, 8'hFF);
        tick(); chk_out("all_fall", 8'h00, 8'h00, 8'hFF, 8'h00);
        tick(); chk_out("all_low", 8'h00, 8'h00, 8'h00, 8'h00);

        btn_raw = 8'h08;
        hold("b3_wait", 5, 8'h00);
        tick(); chk_out("b3_press", 8'h08, 8'h08, 8'h00, 8'h00);
        tick(); chk_out("b3_held", 8'h08, 8'h00, 8'h00, 8'h00);
        btn_raw = 8'h00;
        hold("b3_rel_wait", 5, 8'h08);
        tick(); chk_out("b3_release", 8'h00, 8'h00, 8'h08, 8'h00);
        tick(); chk_out("b3_low", 8'h00, 8'h00, 8'h00, 8'h00);

        btn_raw = 8'h01;
        hold("glitch_hi", 3, 8'h00);
        btn_raw = 8'h00;
        hold("glitch_lo", 10, 8'h00);

        for (int k = 0; k < 10; k++) begin
            btn_raw = (k % 4 < 2) ? 8'h42 : 8'h00;
            tick();
            chk_out("bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        hold("bounce_wait", 3, 8'h00);
        tick(); chk_out("bounce_press", 8'h42, 8'h42, 8'h00, 8'h00);
        tick(); chk_out("bounce_held", 8'h42, 8'h00, 8'h00, 8'h00);
        btn_raw = 8'h00;
        hold("bounce_rel_wait", 5, 8'h42);
        tick(); chk_out("bounce_release", 8'h00, 8'h00, 8'h42, 8'h00);
        tick(); chk_out("bounce_low", 8'h00, 8'h00, 8'h00, 8'h00);

        btn_raw = 8'h04;
        hold("b2_wait", 5, 8'h00);
        tick(); chk_out("b2_press", 8'h04, 8'h04, 8'h00, 8'h00);
        tick(); chk_out("b2_held", 8'h04, 8'h00, 8'h00, 8'h00);
        ena = 1'b0;
        tick(); chk_out("ena_off", 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); chk_out("ena_off2", 8'h00, 8'h00, 8'h00, 8'h00);
        ena = 1'b1;
        hold("ena_wait", 5, 8'h00);
        tick(); chk_out("ena_press", 8'h04, 8'h04, 8'h00, 8'h00);
        tick(); chk_out("ena_held", 8'h04, 8'h00, 8'h00, 8'h00);
        btn_raw = 8'h00;
        hold("b2_rel_wait", 5, 8'h04);
        tick(); chk_out("b2_release", 8'h00, 8'h00, 8'h04, 8'h00);
        tick(); chk_out("b2_low", 8'h00, 8'h00, 8'h00, 8'h00);

        btn_raw = 8'h20;
        hold("b5_wait", 5, 8'h00);
        tick(); chk_out("b5_press", 8'h20, 8'h20, 8'h00, 8'h00);
        hold("b5_hold", 19, 8'h20);
        tick(); chk_out("b5_stuck", STK ? 8'h00 : 8'h20, 8'h00, 8'h00, STK ? 8'h20 : 8'h00);
        tick(); chk_out("b5_stuck2", STK ? 8'h00 : 8'h20, 8'h00, 8'h00, STK ? 8'h20 : 8'h00);
        btn_raw = 8'h00;
        repeat (5) begin
            tick();
            chk_out("b5_rel_wait", STK ? 8'h00 : 8'h20, 8'h00, 8'h00, STK ? 8'h20 : 8'h00);
        end
        tick(); chk_out("b5_release", 8'h00, 8'h00, STK ? 8'h00 : 8'h20, 8'h00);
        tick(); chk_out("b5_low", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
